traffic_sim: RTL and testbench



---
 rtl/traffic_sim.sv | 110 +++++++++++
 tb/tb_traffic_sim.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/traffic_sim.sv
// Intersection environment model: turns the controller's lights into car sensors,
// keeps a saturating car queue per street and flags unsafe light combinations.
module traffic_sim #(
    parameter int unsigned TICK_DIV     = 100000000,
    parameter int unsigned DEPART_TICKS = 2,
    parameter int unsigned QW           = 4
) (
    input  logic          CLK_100M,
    input  logic          R,
    input  logic          ARR_A,
    input  logic          ARR_B,
    input  logic [2:0]    L_A,
    input  logic [2:0]    L_B,
    output logic          T_A,
    output logic          T_B,
    output logic [QW-1:0] Q_A,
    output logic [QW-1:0] Q_B,
    output logic          TICK,
    output logic          VIOL
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DW = (DEPART_TICKS > 1) ? $clog2(DEPART_TICKS) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DEP_LAST  = DW'(DEPART_TICKS - 1);
    localparam logic [QW-1:0] QMAX      = '1;

    function automatic logic one_hot3(input logic [2:0] l);
        return (l == 3'b001) || (l == 3'b010) || (l == 3'b100);
    endfunction

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          tick_next;
    logic [1:0]    arr_in;
    logic [1:0]    s1;
    logic [1:0]    s2;
    logic [1:0]    prev;
    logic [1:0]    arr;
    logic [1:0]    dec;
    logic [1:0]    green;
    logic [DW-1:0] dep    [2];
    logic [QW-1:0] q      [2];
    logic [QW-1:0] q_next [2];
    logic          bad;

    assign arr_in = {ARR_B, ARR_A};
    assign green  = {L_B == 3'b001, L_A == 3'b001};
    assign arr    = s2 & ~prev;
    assign Q_A    = q[0];
    assign Q_B    = q[1];

    // TICK is registered but aligned with the counter reaching its last value.
    always_comb begin
        cnt_next  = (cnt == TICK_LAST) ? '0 : cnt + CW'(1);
        tick_next = (cnt_next == TICK_LAST);
    end

    // A departure only fires on the tick that completes DEPART_TICKS green ticks.
    always_comb begin
        dec = '0;
        for (int i = 0; i < 2; i++) begin
            dec[i]    = green[i] & TICK & (dep[i] == DEP_LAST) & (q[i] != '0);
            q_next[i] = q[i];
            if (arr[i] & ~dec[i]) begin
                q_next[i] = (q[i] == QMAX) ? q[i] : q[i] + QW'(1);
            end else if (dec[i] & ~arr[i]) begin
                q_next[i] = q[i] - QW'(1);
            end
        end
    end

    assign bad = ~one_hot3(L_A) | ~one_hot3(L_B) | (~L_A[2] & ~L_B[2]);

    // Synchronizer and edge history preset high so a held switch is not an arrival.
    always_ff @(posedge CLK_100M or posedge R) begin
        if (R) begin
            cnt  <= '0;
            TICK <= 1'b0;
            s1   <= 2'b11;
            s2   <= 2'b11;
            prev <= 2'b11;
            for (int i = 0; i < 2; i++) begin
                dep[i] <= '0;
                q[i]   <= '0;
            end
            T_A  <= 1'b0;
            T_B  <= 1'b0;
            VIOL <= 1'b0;
        end else begin
            cnt  <= cnt_next;
            TICK <= tick_next;
            s1   <= arr_in;
            s2   <= s1;
            prev <= s2;
            for (int i = 0; i < 2; i++) begin
                if (!green[i]) begin
                    dep[i] <= '0;
                end else if (TICK) begin
                    dep[i] <= (dep[i] == DEP_LAST) ? '0 : dep[i] + DW'(1);
                end
                q[i] <= q_next[i];
            end
            T_A  <= (q_next[0] != '0);
            T_B  <= (q_next[1] != '0);
            VIOL <= VIOL | bad;
        end
    end

endmodule

// File: tb/tb_traffic_sim.sv
// Directed bench for traffic_sim with TICK_DIV=4, DEPART_TICKS=2, QW=4.
module tb_traffic_sim;

    logic       clk = 1'b0;
    logic       R;
    logic       ARR_A;
    logic       ARR_B;
    logic [2:0] L_A;
    logic [2:0] L_B;
    logic       T_A;
    logic       T_B;
    logic [3:0] Q_A;
    logic [3:0] Q_B;
    logic       TICK;
    logic       VIOL;

    int vectors = 0;
    int errs    = 0;

    always #5 clk = ~clk;

    traffic_sim #(.TICK_DIV(4), .DEPART_TICKS(2), .QW(4)) dut (
        .CLK_100M (clk),
        .R        (R),
        .ARR_A    (ARR_A),
        .ARR_B    (ARR_B),
        .L_A      (L_A),
        .L_B      (L_B),
        .T_A      (T_A),
        .T_B      (T_B),
        .Q_A      (Q_A),
        .Q_B      (Q_B),
        .TICK     (TICK),
        .VIOL     (VIOL)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One-cycle switch pulse; returns one cycle after the queue has absorbed it.
    task automatic arrive(input bit b);
        if (b) ARR_B = 1'b1;
        else   ARR_A = 1'b1;
        step(1);
        ARR_A = 1'b0;
        ARR_B = 1'b0;
        step(3);
    endtask

    // Consume the next TICK cycle (the current one if TICK is high now).
    task automatic wait_tick();
        bit got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!got) begin
                if (TICK === 1'b1) got = 1'b1;
                step(1);
            end
        end
        if (!got) check("tick_timeout", 16'd0, 16'd1);
    endtask

    initial begin
        R = 1'b1; ARR_A = 1'b1; ARR_B = 1'b0; L_A = 3'b100; L_B = 3'b001;
        step(3);
        R = 1'b0;
        check("rst_q_a", 16'(Q_A), 16'd0);
        check("rst_t_a", 16'(T_A), 16'd0);
        check("rst_viol", 16'(VIOL), 16'd0);
        check("rst_tick", 16'(TICK), 16'd0);
        for (int k = 1; k <= 4; k++) begin
            step(1);
            check("rel_tick", 16'(TICK), (k == 3) ? 16'd1 : 16'd0);
            check("rel_held_q_a", 16'(Q_A), 16'd0);
            check("rel_viol", 16'(VIOL), 16'd0);
        end

        // arrival latency: increment lands on the third edge after the input edge
        ARR_A = 1'b0;
        step(3);
        ARR_A = 1'b1;
        step(1);
        ARR_A = 1'b0;
        check("lat_e1", 16'(Q_A), 16'd0);
        step(1);
        check("lat_e2", 16'(Q_A), 16'd0);
        step(1);
        check("lat_e3", 16'(Q_A), 16'd1);
        check("lat_t_a", 16'(T_A), 16'd1);
        step(1);
        arrive(1'b0);
        check("arr2_q_a", 16'(Q_A), 16'd2);
        arrive(1'b0);
        check("arr3_q_a", 16'(Q_A), 16'd3);
        check("arr3_t_a", 16'(T_A), 16'd1);

        // queue B drains one car per two green ticks
        L_B = 3'b100;
        arrive(1'b1);
        arrive(1'b1);
        check("qb_fill", 16'(Q_B), 16'd2);
        check("qb_fill_t", 16'(T_B), 16'd1);
        L_B = 3'b001;
        wait_tick();
        check("drain_t1", 16'(Q_B), 16'd2);
        wait_tick();
        check("drain_t2", 16'(Q_B), 16'd1);
        check("drain_t2_t", 16'(T_B), 16'd1);
        wait_tick();
        check("drain_t3", 16'(Q_B), 16'd1);
        wait_tick();
        check("drain_t4", 16'(Q_B), 16'd0);
        check("drain_t4_t", 16'(T_B), 16'd0);
        wait_tick();
        wait_tick();
        check("drain_empty", 16'(Q_B), 16'd0);

        // short green then yellow: partial progress discarded
        L_B = 3'b100;
        arrive(1'b1);
        arrive(1'b1);
        check("qb_refill", 16'(Q_B), 16'd2);
        L_B = 3'b001;
        wait_tick();
        L_B = 3'b010;
        wait_tick();
        wait_tick();
        wait_tick();
        check("yellow_q_b", 16'(Q_B), 16'd2);
        check("yellow_dep", 16'(dut.dep[1]), 16'd0);
        L_B = 3'b001;
        wait_tick();
        check("regreen_t1", 16'(Q_B), 16'd2);
        wait_tick();
        check("regreen_t2", 16'(Q_B), 16'd1);
        wait_tick();
        check("pre_coinc", 16'(Q_B), 16'd1);

        // arrival lands in the same cycle as a departure
        step(1);
        ARR_B = 1'b1;
        step(1);
        ARR_B = 1'b0;
        step(1);
        check("coinc_tick", 16'(TICK), 16'd1);
        step(1);
        check("coinc_q_b", 16'(Q_B), 16'd1);
        L_B = 3'b100;
        step(3);
        check("coinc_after", 16'(Q_B), 16'd1);
        check("coinc_t_b", 16'(T_B), 16'd1);

        // saturation at QMAX
        for (int n = 0; n < 17; n++) arrive(1'b0);
        check("sat_q_a", 16'(Q_A), 16'd15);
        check("sat_t_a", 16'(T_A), 16'd1);

        // both green for one cycle
        L_A = 3'b001;
        L_B = 3'b001;
        check("viol_pre", 16'(VIOL), 16'd0);
        step(1);
        L_A = 3'b100;
        L_B = 3'b100;
        check("viol_set", 16'(VIOL), 16'd1);
        step(3);
        check("viol_sticky", 16'(VIOL), 16'd1);
        check("viol_q_a", 16'(Q_A), 16'd15);
        check("viol_q_b", 16'(Q_B), 16'd1);

        // reset mid-operation
        R = 1'b1;
        #1;
        check("mrst_viol", 16'(VIOL), 16'd0);
        check("mrst_q_a", 16'(Q_A), 16'd0);
        check("mrst_q_b", 16'(Q_B), 16'd0);
        check("mrst_t_a", 16'(T_A), 16'd0);
        check("mrst_t_b", 16'(T_B), 16'd0);
        check("mrst_tick", 16'(TICK), 16'd0);
        step(2);
        R = 1'b0;
        L_A = 3'b011;
        check("illegal_pre", 16'(VIOL), 16'd0);
        step(1);
        check("illegal_set", 16'(VIOL), 16'd1);
        check("mrel_tick1", 16'(TICK), 16'd0);
        L_A = 3'b100;
        step(1);
        check("mrel_tick2", 16'(TICK), 16'd0);
        step(1);
        check("mrel_tick3", 16'(TICK), 16'd1);
        check("illegal_sticky", 16'(VIOL), 16'd1);

        R = 1'b1;
        #1;
        check("final_rst_viol", 16'(VIOL), 16'd0);
        step(1);
        R = 1'b0;
        step(2);
        check("final_q_a", 16'(Q_A), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
